glitcbus_space_router: RTL

Parametrised GLITCBUS local-side address router and readback collector, sitting between `glitcbus_slave_v2` and the register-space modules (control, phase scanner, datapath, RITC, DAC, I2C). Generalises the fixed 8-way decode and combinational readback mux to N spaces with a configurable decode field and per-space aliasing. Adds a registered strobe/ack handshake, so slow spaces (I2C, DAC shift) can stretch reads. Adds a timeout and error reporting for unmapped or silent spaces.

---
 rtl/glitcbus_space_router_if.sv | 35 +++
 rtl/glitcbus_space_router.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/glitcbus_space_router_if.sv
// Local-side GLITCBUS signal bundle for the space router: upstream request/readback
// plus the per-space strobe, select and readback lines.
interface glitcbus_space_router_if #(
    parameter int NSPACE  = 8,
    parameter int SEL_LSB = 4
);
    logic [15:0]          adr_i;
    logic [31:0]          dat_i;
    logic                 wr_i;
    logic                 rd_i;
    logic                 clr_i;
    logic [32*NSPACE-1:0] space_dat_i;
    logic [NSPACE-1:0]    space_ack_i;

    logic [NSPACE-1:0]    sel_o;
    logic                 wr_o;
    logic                 rd_o;
    logic [SEL_LSB-1:0]   adr_o;
    logic [31:0]          wdat_o;
    logic [31:0]          dat_o;
    logic                 ack_o;
    logic                 err_o;
    logic                 busy_o;
    logic                 overrun_o;

    modport slave (
        input  adr_i, dat_i, wr_i, rd_i, clr_i, space_dat_i, space_ack_i,
        output sel_o, wr_o, rd_o, adr_o, wdat_o, dat_o, ack_o, err_o, busy_o, overrun_o
    );

    modport master (
        output adr_i, dat_i, wr_i, rd_i, clr_i, space_dat_i, space_ack_i,
        input  sel_o, wr_o, rd_o, adr_o, wdat_o, dat_o, ack_o, err_o, busy_o, overrun_o
    );
endinterface

// File: rtl/glitcbus_space_router.sv
// GLITCBUS address router: decodes a space index (with optional aliasing), strobes the
// selected space, collects readback on a fixed or ack-driven handshake, and times out.
module glitcbus_space_router #(
    parameter int          NSPACE     = 8,
    parameter int          SEL_LSB    = 4,
    parameter int          SEL_BITS   = 4,
    parameter logic [15:0] ALIAS_MASK = 16'h0000,
    parameter logic [15:0] ACK_MASK   = 16'h0000,
    parameter int          TIMEOUT    = 31,
    parameter logic [31:0] UNMAPPED   = 32'hDEADBEEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    glitcbus_space_router_if.slave bus
);

    localparam int SW = (NSPACE > 1) ? $clog2(NSPACE) : 1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state_q;
    logic [NSPACE-1:0]  sel_q;
    logic               wr_q;
    logic               rd_q;
    logic               ack_q;
    logic               err_q;
    logic               busy_q;
    logic               overrun_q;
    logic [SEL_LSB-1:0] adr_q;
    logic [31:0]        wdat_q;
    logic [31:0]        dat_q;
    logic [7:0]         cnt_q;
    logic [SW-1:0]      space_q;
    logic               isRead_q;
    logic               reqErr_q;
    logic               ackSeen_q;
    logic [31:0]        capDat_q;

    logic               reqValid;
    logic               reqBoth;
    logic               reqMapped;
    logic [SW-1:0]      reqSpace;
    logic [NSPACE-1:0]  reqOneHot;
    logic               midTransfer;
    int                 kIdx;
    logic [31:0]        curDat;
    logic               curAck;
    logic               curIsAck;

    assign reqValid    = bus.wr_i | bus.rd_i;
    assign reqBoth     = bus.wr_i & bus.rd_i;
    assign midTransfer = (state_q == ST_STROBE) || (state_q == ST_WAIT);

    // Indices past NSPACE are only mapped when their alias bit points back at a real space.
    always_comb begin
        kIdx      = int'({{(32-SEL_BITS){1'b0}}, bus.adr_i[SEL_LSB +: SEL_BITS]});
        reqMapped = 1'b0;
        reqSpace  = '0;
        reqOneHot = '0;
        for (int i = 0; i < NSPACE; i++) begin
            if ((kIdx == i) || (ALIAS_MASK[i] && (kIdx == i + NSPACE))) begin
                reqMapped    = 1'b1;
                reqSpace     = SW'(i);
                reqOneHot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        curDat   = '0;
        curAck   = 1'b0;
        curIsAck = 1'b0;
        for (int i = 0; i < NSPACE; i++) begin
            if (space_q == SW'(i)) begin
                curDat   = bus.space_dat_i[32*i +: 32];
                curAck   = bus.space_ack_i[i];
                curIsAck = ACK_MASK[i];
            end
        end
    end

    // DONE and ERR accept a new request directly so back-to-back transfers lose no cycle;
    // an ack seen during STROBE is parked in capDat_q so completion still lands in WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            dat_q     <= '0;
            cnt_q     <= '0;
            space_q   <= '0;
            isRead_q  <= 1'b0;
            reqErr_q  <= 1'b0;
            ackSeen_q <= 1'b0;
            capDat_q  <= '0;
        end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;

            if (reqValid && midTransfer) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_i) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    sel_q <= '0;
                    if (reqValid) begin
                        state_q   <= ST_STROBE;
                        busy_q    <= 1'b1;
                        adr_q     <= bus.adr_i[SEL_LSB-1:0];
                        wdat_q    <= bus.dat_i;
                        isRead_q  <= bus.rd_i;
                        space_q   <= reqSpace;
                        cnt_q     <= '0;
                        ackSeen_q <= 1'b0;
                        reqErr_q  <= reqBoth || !reqMapped;
                        if (!reqBoth && reqMapped) begin
                            sel_q <= reqOneHot;
                            wr_q  <= bus.wr_i;
                            rd_q  <= bus.rd_i;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                ST_STROBE: begin
                    if (reqErr_q) begin
                        state_q <= ST_ERR;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        if (isRead_q) begin
                            dat_q <= UNMAPPED;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                        if (curIsAck && curAck) begin
                            ackSeen_q <= 1'b1;
                            capDat_q  <= curDat;
                        end
                    end
                end

                // Timeout fires on the first WAIT edge that finds the counter already at TIMEOUT.
                ST_WAIT: begin
                    if (!curIsAck || ackSeen_q || curAck) begin
                        state_q <= ST_DONE;
                        ack_q   <= 1'b1;
                        sel_q   <= '0;
                        if (isRead_q) begin
                            dat_q <= ackSeen_q ? capDat_q : curDat;
                        end
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        state_q <= ST_ERR;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        sel_q   <= '0;
                        if (isRead_q) begin
                            dat_q <= UNMAPPED;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    sel_q   <= '0;
                end
            endcase
        end
    end

    assign bus.sel_o     = sel_q;
    assign bus.wr_o      = wr_q;
    assign bus.rd_o      = rd_q;
    assign bus.adr_o     = adr_q;
    assign bus.wdat_o    = wdat_q;
    assign bus.dat_o     = dat_q;
    assign bus.ack_o     = ack_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;

endmodule
